// File: rtl/xgmii_tx_framer.sv
// Client-side XGMII transmit framer with reconciliation-sublayer link-fault handling.
// Every output except tx_ready is registered. The word on the bus is the one chosen at the previous edge.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | between frames, Idle on the bus, waiting for tx_valid
// S_DATA  | Start or client words in flight, tx_ready high
// S_TERM  | full last word sent, next edge emits the terminate word
// S_ABORT | Error word on the bus after an underrun or a local fault
// S_IFG   | inter-frame Idle words, counted by ifg_cnt
// S_FAULT | RF ordered sets, waiting for rx_local_fault to stay clear
module xgmii_tx_framer #(
    parameter int IFG_CYCLES         = 2,
    parameter int FAULT_CLEAR_CYCLES = 128
) (
    input  logic        xaui_clk,
    input  logic        reset_n,
    input  logic [63:0] tx_data,
    input  logic        tx_valid,
    input  logic        tx_eof,
    input  logic [2:0]  tx_bytes,
    output logic        tx_ready,
    input  logic        rx_local_fault,
    input  logic        rx_remote_fault,
    output logic [63:0] xgmii_txd,
    output logic [7:0]  xgmii_txc,
    output logic        tx_abort,
    output logic        fault_active,
    output logic [31:0] frame_count
);

    localparam logic [63:0] IDLE_D  = 64'h0707070707070707;
    localparam logic [63:0] START_D = 64'hD5555555555555FB;
    localparam logic [63:0] ERR_D   = 64'hFEFEFEFEFEFEFEFE;
    localparam logic [63:0] RF_D    = 64'h0200009C0200009C;
    localparam logic [63:0] TERM_D  = 64'h07070707070707FD;

    // Terminate path loads IFG_CYCLES so that IFG_CYCLES+1 Idles follow the terminate word;
    // abort/fault exits already emit one Idle on the leaving edge and load one less.
    localparam logic [3:0]  IFG_LOAD   = 4'(IFG_CYCLES);
    localparam logic [3:0]  IFG_LOAD_S = 4'(IFG_CYCLES - 1);
    localparam logic [15:0] CLR_TARGET = 16'(FAULT_CLEAR_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_TERM,
        S_ABORT,
        S_IFG,
        S_FAULT
    } state_t;

    state_t      state;
    logic [3:0]  ifg_cnt;
    logic [15:0] clr_cnt;
    logic [63:0] eof_txd;
    logic [7:0]  eof_txc;

    assign tx_ready = (state == S_DATA) && !rx_local_fault;

    always_comb begin
        eof_txd = tx_data;
        eof_txc = 8'hFF << tx_bytes;
        for (int i = 0; i < 8; i++) begin
            if (i == int'(tx_bytes)) begin
                eof_txd[i*8 +: 8] = 8'hFD;
            end else if (i > int'(tx_bytes)) begin
                eof_txd[i*8 +: 8] = 8'h07;
            end
        end
    end

    always_ff @(posedge xaui_clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            xgmii_txd    <= IDLE_D;
            xgmii_txc    <= 8'hFF;
            tx_abort     <= 1'b0;
            fault_active <= 1'b0;
            frame_count  <= 32'd0;
            ifg_cnt      <= 4'd0;
            clr_cnt      <= 16'd0;
        end else begin
            xgmii_txd    <= IDLE_D;
            xgmii_txc    <= 8'hFF;
            tx_abort     <= 1'b0;
            fault_active <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rx_local_fault) begin
                        xgmii_txd    <= RF_D;
                        xgmii_txc    <= 8'h11;
                        fault_active <= 1'b1;
                        clr_cnt      <= 16'd0;
                        state        <= S_FAULT;
                    end else if (tx_valid && !rx_remote_fault) begin
                        xgmii_txd <= START_D;
                        xgmii_txc <= 8'h01;
                        state     <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (rx_local_fault || !tx_valid) begin
                        xgmii_txd <= ERR_D;
                        tx_abort  <= 1'b1;
                        state     <= S_ABORT;
                    end else if (tx_eof && tx_bytes == 3'd0) begin
                        xgmii_txd <= tx_data;
                        xgmii_txc <= 8'h00;
                        state     <= S_TERM;
                    end else if (tx_eof) begin
                        xgmii_txd   <= eof_txd;
                        xgmii_txc   <= eof_txc;
                        frame_count <= frame_count + 32'd1;
                        ifg_cnt     <= IFG_LOAD;
                        state       <= S_IFG;
                    end else begin
                        xgmii_txd <= tx_data;
                        xgmii_txc <= 8'h00;
                    end
                end
                S_TERM: begin
                    xgmii_txd   <= TERM_D;
                    frame_count <= frame_count + 32'd1;
                    ifg_cnt     <= IFG_LOAD;
                    state       <= S_IFG;
                end
                S_ABORT: begin
                    if (rx_local_fault) begin
                        xgmii_txd    <= RF_D;
                        xgmii_txc    <= 8'h11;
                        fault_active <= 1'b1;
                        clr_cnt      <= 16'd0;
                        state        <= S_FAULT;
                    end else begin
                        ifg_cnt <= IFG_LOAD_S;
                        state   <= S_IFG;
                    end
                end
                S_IFG: begin
                    if (rx_local_fault) begin
                        xgmii_txd    <= RF_D;
                        xgmii_txc    <= 8'h11;
                        fault_active <= 1'b1;
                        clr_cnt      <= 16'd0;
                        state        <= S_FAULT;
                    end else if (ifg_cnt == 4'd0) begin
                        state <= S_IDLE;
                    end else begin
                        ifg_cnt <= ifg_cnt - 4'd1;
                    end
                end
                S_FAULT: begin
                    if (rx_local_fault) begin
                        xgmii_txd    <= RF_D;
                        xgmii_txc    <= 8'h11;
                        fault_active <= 1'b1;
                        clr_cnt      <= 16'd0;
                    end else if (clr_cnt == CLR_TARGET) begin
                        clr_cnt <= 16'd0;
                        ifg_cnt <= IFG_LOAD_S;
                        state   <= S_IFG;
                    end else begin
                        xgmii_txd    <= RF_D;
                        xgmii_txc    <= 8'h11;
                        fault_active <= 1'b1;
                        clr_cnt      <= clr_cnt + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xgmii_tx_framer.sv
// Bench for xgmii_tx_framer: per-scenario tasks, expected bus words queued at drive time
// and popped after the edge that registers them.
module tb_xgmii_tx_framer;

    localparam logic [63:0] IDLE_D  = 64'h0707070707070707;
    localparam logic [63:0] START_D = 64'hD5555555555555FB;
    localparam logic [63:0] ERR_D   = 64'hFEFEFEFEFEFEFEFE;
    localparam logic [63:0] RF_D    = 64'h0200009C0200009C;
    localparam logic [63:0] TERM_D  = 64'h07070707070707FD;

    logic        xaui_clk = 1'b0;
    logic        reset_n;
    logic [63:0] tx_data;
    logic        tx_valid;
    logic        tx_eof;
    logic [2:0]  tx_bytes;
    logic        tx_ready;
    logic        rx_local_fault;
    logic        rx_remote_fault;
    logic [63:0] xgmii_txd;
    logic [7:0]  xgmii_txc;
    logic        tx_abort;
    logic        fault_active;
    logic [31:0] frame_count;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  c;
        logic        ab;
        logic        fa;
    } exp_t;

    exp_t  exp_q[$];
    int    tests_run    = 0;
    int    tests_failed = 0;
    string cur_test     = "none";

    xgmii_tx_framer #(.IFG_CYCLES(2), .FAULT_CLEAR_CYCLES(128)) dut (
        .xaui_clk       (xaui_clk),
        .reset_n        (reset_n),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_eof         (tx_eof),
        .tx_bytes       (tx_bytes),
        .tx_ready       (tx_ready),
        .rx_local_fault (rx_local_fault),
        .rx_remote_fault(rx_remote_fault),
        .xgmii_txd      (xgmii_txd),
        .xgmii_txc      (xgmii_txc),
        .tx_abort       (tx_abort),
        .fault_active   (fault_active),
        .frame_count    (frame_count)
    );

    always #5 xaui_clk = ~xaui_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached in %s", cur_test);
        $fatal(1, "watchdog");
    end

    // Queue the word the next edge must register, clock once, then pop and compare.
    task automatic cycle(input logic [63:0] d, input logic [7:0] c, input logic ab, input logic fa);
        exp_t e;
        e.d = d; e.c = c; e.ab = ab; e.fa = fa;
        exp_q.push_back(e);
        @(posedge xaui_clk);
        #1;
        e = exp_q.pop_front();
        tests_run++;
        if (xgmii_txd !== e.d || xgmii_txc !== e.c || tx_abort !== e.ab || fault_active !== e.fa) begin
            tests_failed++;
            $display("FAIL %s bus word: got txd=%h txc=%h abort=%b fault=%b, want txd=%h txc=%h abort=%b fault=%b",
                     cur_test, xgmii_txd, xgmii_txc, tx_abort, fault_active, e.d, e.c, e.ab, e.fa);
        end
    endtask

    task automatic idles(input int n);
        for (int i = 0; i < n; i++) cycle(IDLE_D, 8'hFF, 1'b0, 1'b0);
    endtask

    task automatic rfs(input int n);
        for (int i = 0; i < n; i++) cycle(RF_D, 8'h11, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        cur_test = "reset";
        reset_n = 1'b0; tx_data = '0; tx_valid = 1'b0; tx_eof = 1'b0; tx_bytes = 3'd0;
        rx_local_fault = 1'b0; rx_remote_fault = 1'b0;
        #12;
        tests_run++;
        if (xgmii_txd !== IDLE_D || xgmii_txc !== 8'hFF || tx_abort !== 1'b0 || fault_active !== 1'b0
            || frame_count !== 32'd0 || tx_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset values: got txd=%h txc=%h abort=%b fault=%b count=%0d ready=%b, want idle/FF/0/0/0/0",
                     xgmii_txd, xgmii_txc, tx_abort, fault_active, frame_count, tx_ready);
        end
        reset_n = 1'b1;
        idles(2);
    endtask

    task automatic test_two_word();
        cur_test = "two_word";
        tx_valid = 1'b1; tx_data = 64'h1111111111111111; tx_eof = 1'b0;
        cycle(START_D, 8'h01, 1'b0, 1'b0);
        tests_run++;
        if (tx_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL two_word ready in DATA: got %b, want 1", tx_ready);
        end
        cycle(64'h1111111111111111, 8'h00, 1'b0, 1'b0);
        tx_data = 64'h2222222222222222; tx_eof = 1'b1; tx_bytes = 3'd0;
        cycle(64'h2222222222222222, 8'h00, 1'b0, 1'b0);
        tx_valid = 1'b0; tx_eof = 1'b0;
        cycle(TERM_D, 8'hFF, 1'b0, 1'b0);
        tests_run++;
        if (frame_count !== 32'd1) begin
            tests_failed++;
            $display("FAIL two_word frame_count: got %0d, want 1", frame_count);
        end
        idles(4);
    endtask

    task automatic test_partial_eof();
        cur_test = "partial_eof";
        tx_valid = 1'b1; tx_data = 64'h8877665544332211; tx_eof = 1'b1; tx_bytes = 3'd3;
        cycle(START_D, 8'h01, 1'b0, 1'b0);
        cycle(64'h07070707FD332211, 8'hF8, 1'b0, 1'b0);
        tests_run++;
        if (tx_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL partial_eof ready in IFG: got %b, want 0", tx_ready);
        end
        tx_data = 64'hAABBCCDDEEFF0011; tx_bytes = 3'd7;
        idles(3);
        cycle(START_D, 8'h01, 1'b0, 1'b0);
        cycle(64'hFDBBCCDDEEFF0011, 8'h80, 1'b0, 1'b0);
        tx_valid = 1'b0; tx_eof = 1'b0; tx_bytes = 3'd0;
        idles(3);
        tests_run++;
        if (frame_count !== 32'd3) begin
            tests_failed++;
            $display("FAIL partial_eof frame_count: got %0d, want 3", frame_count);
        end
    endtask

    task automatic test_underrun();
        cur_test = "underrun";
        tx_valid = 1'b1; tx_data = 64'h3333333333333333; tx_eof = 1'b0;
        cycle(START_D, 8'h01, 1'b0, 1'b0);
        cycle(64'h3333333333333333, 8'h00, 1'b0, 1'b0);
        tx_valid = 1'b0;
        cycle(ERR_D, 8'hFF, 1'b1, 1'b0);
        idles(3);
        tests_run++;
        if (frame_count !== 32'd3) begin
            tests_failed++;
            $display("FAIL underrun frame_count: got %0d, want 3", frame_count);
        end
    endtask

    task automatic test_local_fault();
        cur_test = "local_fault";
        tx_valid = 1'b1; tx_data = 64'h4444444444444444; tx_eof = 1'b0;
        cycle(START_D, 8'h01, 1'b0, 1'b0);
        cycle(64'h4444444444444444, 8'h00, 1'b0, 1'b0);
        rx_local_fault = 1'b1;
        #1;
        tests_run++;
        if (tx_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL local_fault ready gated: got %b, want 0", tx_ready);
        end
        cycle(ERR_D, 8'hFF, 1'b1, 1'b0);
        tx_valid = 1'b0;
        rfs(9);
        rx_local_fault = 1'b0;
        rfs(50);
        rx_local_fault = 1'b1;
        rfs(5);
        rx_local_fault = 1'b0;
        rfs(128);
        idles(3);
    endtask

    task automatic test_remote_fault();
        cur_test = "remote_fault";
        tx_valid = 1'b1; rx_remote_fault = 1'b1;
        tx_data = 64'h5555555555555555; tx_eof = 1'b1; tx_bytes = 3'd0;
        for (int i = 0; i < 4; i++) begin
            cycle(IDLE_D, 8'hFF, 1'b0, 1'b0);
            tests_run++;
            if (tx_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL remote_fault ready blocked: got %b, want 0", tx_ready);
            end
        end
        rx_remote_fault = 1'b0;
        cycle(START_D, 8'h01, 1'b0, 1'b0);
        rx_remote_fault = 1'b1;
        cycle(64'h5555555555555555, 8'h00, 1'b0, 1'b0);
        tx_valid = 1'b0; tx_eof = 1'b0;
        cycle(TERM_D, 8'hFF, 1'b0, 1'b0);
        tests_run++;
        if (frame_count !== 32'd4) begin
            tests_failed++;
            $display("FAIL remote_fault frame_count: got %0d, want 4", frame_count);
        end
        idles(3);
        rx_remote_fault = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        cur_test = "reset_mid_frame";
        tx_valid = 1'b1; tx_data = 64'h6666666666666666; tx_eof = 1'b0;
        cycle(START_D, 8'h01, 1'b0, 1'b0);
        cycle(64'h6666666666666666, 8'h00, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (xgmii_txd !== IDLE_D || xgmii_txc !== 8'hFF || frame_count !== 32'd0 || tx_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_frame async idle: got txd=%h txc=%h count=%0d ready=%b, want idle/FF/0/0",
                     xgmii_txd, xgmii_txc, frame_count, tx_ready);
        end
        @(posedge xaui_clk);
        @(posedge xaui_clk);
        #1;
        reset_n = 1'b1;
        tx_data = 64'h0102030405060708; tx_eof = 1'b1; tx_bytes = 3'd5;
        cycle(START_D, 8'h01, 1'b0, 1'b0);
        cycle(64'h0707FD0405060708, 8'hE0, 1'b0, 1'b0);
        tx_valid = 1'b0; tx_eof = 1'b0; tx_bytes = 3'd0;
        idles(3);
        tests_run++;
        if (frame_count !== 32'd1) begin
            tests_failed++;
            $display("FAIL reset_mid_frame frame_count: got %0d, want 1", frame_count);
        end
    endtask

    initial begin
        test_reset();
        test_two_word();
        test_partial_eof();
        test_underrun();
        test_local_fault();
        test_remote_fault();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/xgmii_tx_framer.md
# xgmii_tx_framer

Client-side XGMII transmit framer and reconciliation-sublayer transmit logic for the 10GbE/XAUI path. It takes a 64-bit word stream from the packet engine and builds framed XGMII words for `xgmii_txd`/`xgmii_txc` on the XAUI core. Framing includes start and preamble, terminate placement, inter-frame idles and error insertion on underrun. It also answers link faults reported by the receive side: it sends remote-fault ordered sets while a local fault is present, and it suppresses new frames while a remote fault is present.

## Interface
Parameters:
- IFG_CYCLES, 2: number of all-idle words after the word carrying the terminate. Legal range is 1..15.
- FAULT_CLEAR_CYCLES, 128: number of consecutive cycles `rx_local_fault` must stay low before the block leaves FAULT. Legal range is 1..65535.

Ports:
- xaui_clk  in  1  transmit clock, 156.25 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- tx_data  in  64  client word; lane 0 is [7:0] and is sent first.
- tx_valid  in  1  client word valid.
- tx_eof  in  1  marks the last word of a frame.
- tx_bytes  in  3  valid bytes in the eof word; 0 means 8.
- tx_ready  out  1  word accepted on an edge where tx_valid and tx_ready are both high.
- rx_local_fault  in  1  local fault seen by the receiver, synchronous to xaui_clk.
- rx_remote_fault  in  1  remote fault seen by the receiver.
- xgmii_txd  out  64  to the XAUI core.
- xgmii_txc  out  8  to the XAUI core.
- tx_abort  out  1  one-cycle pulse, aligned with the error word.
- fault_active  out  1  high while in FAULT.
- frame_count  out  32  count of terminates sent; wraps.

## Operation
Fixed words:
- Idle: txd=0x0707070707070707, txc=0xFF.
- Start: txd=0xD5555555555555FB, txc=0x01.
- Error: txd=0xFEFEFEFEFEFEFEFE, txc=0xFF.
- RF: txd=0x0200009C0200009C, txc=0x11.

States and transitions:
- IDLE: output is Idle.
  - If rx_local_fault: go to FAULT.
  - Else if tx_valid and not rx_remote_fault: output Start and go to DATA.
  - tx_ready is low in IDLE.
- DATA: tx_ready=1.
  - Accepted non-eof word: output the data word with txc=0x00.
  - Accepted eof word with tx_bytes=0: output the data word and go to TERM.
  - Accepted eof word with tx_bytes=n (1..7):
    - lanes 0..n-1 carry data;
    - lane n = 0xFD;
    - lanes n+1..7 = 0x07;
    - txc bits n..7 set;
    - frame_count++;
    - go to IFG.
  - tx_valid low in DATA is an underrun: go to ABORT.
  - rx_local_fault high in DATA: go to ABORT. This has priority over an accepted word; the word is not consumed because tx_ready is low the same cycle.
- TERM: output txd=0x07070707070707FD, txc=0xFF; frame_count++; go to IFG.
- ABORT: output Error; pulse tx_abort.
  - If rx_local_fault: go to FAULT.
  - Else: go to IFG.
  - The client discards the remainder of the aborted frame.
- IFG: output Idle for IFG_CYCLES words, then go to IDLE. rx_local_fault preempts this and goes to FAULT.
- FAULT: output RF; fault_active=1.
  - A 16-bit clear counter increments while rx_local_fault is low and resets to 0 while it is high.
  - When the counter reaches FAULT_CLEAR_CYCLES: go to IFG.
- rx_remote_fault only blocks IDLE→DATA. A frame already in progress completes normally.
- tx_ready is combinational: (state==DATA) && !rx_local_fault.

## Timing
- All outputs except tx_ready are registered.
- Reset values: xgmii_txd/xgmii_txc = Idle, state=IDLE, tx_abort=0, fault_active=0, frame_count=0, internal counters=0.
- Asserting reset_n low mid-frame forces Idle on the outputs immediately (asynchronously). No terminate and no error word is sent.
- Latency: a word accepted at edge k appears on xgmii_txd from edge k to edge k+1, i.e. one cycle later.
- Start timing: Start is registered on the edge where IDLE sees tx_valid. The first data word is accepted on the following edge, so the start word and the data words are contiguous.
- The fault input is sampled at each edge. The first Error or RF word appears one cycle after rx_local_fault is seen high.
- frame_count increments on the edge that registers the terminate-carrying word; 0xFFFFFFFF wraps to 0.
- Minimum frame-to-frame spacing, from the terminate word to the next Start: 1 + IFG_CYCLES + 1 words.

## Test plan
- 2-word frame, D0=0x1111…, D1=0x2222…, tx_eof on D1, tx_bytes=0 → Start, D0, D1, 0x07…07FD/0xFF, then 2 Idle, then Idle in IDLE. frame_count=1.
- 1-word frame, tx_bytes=3, data 0x8877665544332211 → eof word txd=0x07070707FD332211, txc=0xF8. Next Start appears no earlier than 3 Idle words later.
- Underrun: tx_valid dropped after one DATA word → Error word with tx_abort=1 for one cycle, then 2 Idle. frame_count unchanged.
- rx_local_fault raised mid-frame and held 10 cycles, then cleared → Error, then RF words with fault_active=1. Exactly 128 RF words after the clear, then Idle. A 5-cycle re-pulse during clearing restarts the 128-cycle count.
- rx_remote_fault high with tx_valid high → Idle only and tx_ready=0. Start appears one cycle after rx_remote_fault falls.
- reset_n pulsed low during DATA → Idle immediately, frame_count=0, a fresh frame after release frames correctly.
